// File: rtl/rr_arb8_pkg.sv
// rtl/rr_arb8_pkg.sv - shared constants and state encoding for the rr_arb8 arbiter
package rr_arb8_pkg;

  localparam int N_REQ = 8;
  localparam int SRC_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

endpackage

// File: rtl/mux16.sv
// rtl/mux16.sv - library 16-way WIDTH-bit data mux
module mux16 #(
  parameter int WIDTH = 32
) (
  input  logic [16*WIDTH-1:0] din,
  input  logic [3:0]          sel,
  output logic [WIDTH-1:0]    dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < 16; i++) begin
      if (sel == 4'(i)) dout = din[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - circular priority encoder: first set request at or after ptr
module rr_pick8
  import rr_arb8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic             any,
  output logic [SRC_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SRC_W-1:0]   off;

  // rot[i] is request (ptr+i) mod 8, so the lowest set bit is the winner offset
  assign dbl = {req, req};
  assign rot = dbl[ptr +: N_REQ];

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SRC_W'(i);
    end
  end

  assign any = |req;
  assign idx = ptr + off;

endmodule

// File: rtl/rr_arb8.sv
// rtl/rr_arb8.sv - eight-requester round-robin arbiter with burst ownership and one output stage
module rr_arb8
  import rr_arb8_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_rdy,
  output logic                   out_vld,
  output logic [WIDTH-1:0]       out_data,
  output logic [SRC_W-1:0]       out_src,
  input  logic                   out_rdy,
  output logic                   busy
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST);

  state_e           state, state_nxt;
  logic [SRC_W-1:0] ptr, ptr_nxt;
  logic [SRC_W-1:0] grant, grant_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [SRC_W-1:0] sel_idx;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_any;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] mux_out;

  rr_pick8 u_pick (
    .req (req_vld),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  mux16 #(.WIDTH(WIDTH)) u_mux (
    .din  ({{((16 - N_REQ) * WIDTH){1'b0}}, req_data}),
    .sel  ({1'b0, sel_idx}),
    .dout (mux_out)
  );

  assign can_load = !out_vld || out_rdy;
  assign busy     = (state == OWN) || out_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      cnt      <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      grant <= grant_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        out_vld  <= 1'b1;
        out_data <= mux_out;
        out_src  <= sel_idx;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (load) begin
          grant_nxt = pick_idx;
          cnt_nxt   = 4'd1;
          if (BURST_LAST == 4'd1) ptr_nxt = pick_idx + 3'd1;
          else                    state_nxt = OWN;
        end
      end
      OWN: begin
        if (load) begin
          cnt_nxt = cnt + 4'd1;
          if (cnt + 4'd1 == BURST_LAST) begin
            state_nxt = IDLE;
            ptr_nxt   = grant + 3'd1;
          end
        end else if (can_load) begin
          // owner went quiet: give up the grant, costing one bubble cycle
          state_nxt = IDLE;
          ptr_nxt   = grant + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_idx = grant;
    load    = 1'b0;
    if (state == IDLE) begin
      sel_idx = pick_idx;
      load    = pick_any && can_load;
    end else begin
      load = can_load && req_vld[grant];
    end
    if (!rst_n) load = 1'b0;
    req_rdy = load ? (N_REQ'(1) << sel_idx) : '0;
  end

endmodule
